// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: shared state/parity types and sizing helpers for the UART receive path.
// Revision: 1.0
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    BREAK = 3'd5
  } rx_state_e;

  // Wide enough to count up to 9 data bits or 2 stop bits.
  localparam int IDX_W = 4;

  function automatic int bit_period(input int clk, input int baud);
    return clk / baud;
  endfunction

  function automatic int cnt_width(input int period);
    return (period > 2) ? $clog2(period) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_buf.sv
`default_nettype none
// uart_rx_fifo_buf: first-word fall-through FIFO; drops pushes when full unless a pop frees a slot.
// Revision: 1.0
module uart_rx_fifo_buf #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             overrun_q;
  logic             w_empty, w_full, w_pop, w_push;

  assign w_empty = (wr_q == rd_q);
  assign w_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign w_pop   = pop_i && !w_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign w_push  = push_i && (!w_full || w_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (w_push) wr_d = wr_q + 1'b1;
    if (w_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      overrun_q <= push_i && !w_push;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign valid_o   = !w_empty;
  assign data_o    = w_empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// uart_rx_fifo: configurable UART receiver with per-word parity/framing flags and FWFT output FIFO.
// Optional UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around mid-bit, sample point one clock later.
// Revision: 1.0
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun,
  output logic                 busy
);
  localparam int BIT_PERIOD  = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int CNT_W       = cnt_width(BIT_PERIOD);
  localparam int WORD_W      = DATA_BITS + 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int SAMPLE_DLY  = 1;
`else
  localparam int SAMPLE_DLY  = 0;
`endif
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_PERIOD - 1 + SAMPLE_DLY);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_PERIOD - 1);

  logic [1:0]           sync_q;
  logic                 rx_s, bit_s;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_bad_q, frm_bad_q, push_q;
  logic [WORD_W-1:0]    word_q, head;
  logic                 w_mid, w_frm_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rx_s};
  end
  // rx_s is the mid+1 sample, hist_q[0] mid, hist_q[1] mid-1.
  assign bit_s = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign bit_s = rx_s;
`endif

  assign w_mid     = (cnt_q == BIT_LAST);
  assign w_frm_bad = frm_bad_q | ~bit_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      par_bad_q <= 1'b0;
      frm_bad_q <= 1'b0;
      push_q    <= 1'b0;
      word_q    <= '0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= START;
        end
        START: begin
          if (cnt_q == START_LAST) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            par_bad_q <= 1'b0;
            frm_bad_q <= 1'b0;
            state_q   <= bit_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (w_mid) begin
            cnt_q   <= '0;
            shreg_q <= {bit_s, shreg_q[DATA_BITS-1:1]};
            if (idx_q == IDX_W'(DATA_BITS - 1)) begin
              idx_q   <= '0;
              state_q <= (PARITY != int'(NONE)) ? PAR : STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PAR: begin
          if (w_mid) begin
            cnt_q     <= '0;
            par_bad_q <= ((^shreg_q) ^ bit_s) != (PARITY == int'(ODD));
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (w_mid) begin
            cnt_q     <= '0;
            frm_bad_q <= w_frm_bad;
            if (idx_q == IDX_W'(STOP_BITS - 1)) begin
              idx_q   <= '0;
              push_q  <= 1'b1;
              word_q  <= {w_frm_bad, par_bad_q, shreg_q};
              state_q <= w_frm_bad ? BREAK : IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BREAK: begin
          cnt_q <= '0;
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_rx_fifo_buf #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push_q),
    .data_i    (word_q),
    .pop_i     (ready),
    .data_o    (head),
    .valid_o   (valid),
    .overrun_o (overrun)
  );

  assign data_out   = head[DATA_BITS-1:0];
  assign parity_err = head[DATA_BITS];
  assign frame_err  = head[DATA_BITS+1];
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// tb_uart_rx_fifo: scoreboard bench for an 8N1 and a 7E1 receiver at 16 clocks per bit.
// Revision: 1.0
module tb_uart_rx_fifo;
  localparam int CLK_FREQ = 160000;
  localparam int BAUD     = 10000;
  localparam int BP       = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx8, rx7, ready8, ready7;
  logic [7:0] data8;
  logic [6:0] data7;
  logic       pe8, fe8, valid8, ovr8, busy8;
  logic       pe7, fe7, valid7, ovr7, busy7;

  int checks = 0;
  int errors = 0;
  int words8 = 0;
  int words7 = 0;
  int ovr_cnt8 = 0;
  logic [10:0] q8[$];
  logic [10:0] q7[$];
  logic [10:0] e8, e7;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx8), .data_out(data8),
    .parity_err(pe8), .frame_err(fe8), .valid(valid8), .ready(ready8),
    .overrun(ovr8), .busy(busy8)
  );

  uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_p (
    .clk(clk), .reset(reset), .rx(rx7), .data_out(data7),
    .parity_err(pe7), .frame_err(fe7), .valid(valid7), .ready(ready7),
    .overrun(ovr7), .busy(busy7)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: words are compared as the consumer accepts them.
  always @(negedge clk) begin
    if (!reset && valid8 && ready8) begin
      if (q8.size() == 0) begin
        check("q8_nonempty_on_pop", 32'(q8.size()), 32'd1);
      end else begin
        e8 = q8.pop_front();
        check("data8", 32'(data8), 32'(e8[7:0]));
        check("perr8", 32'(pe8), 32'(e8[9]));
        check("ferr8", 32'(fe8), 32'(e8[10]));
      end
      words8++;
    end
    if (!reset && valid7 && ready7) begin
      if (q7.size() == 0) begin
        check("q7_nonempty_on_pop", 32'(q7.size()), 32'd1);
      end else begin
        e7 = q7.pop_front();
        check("data7", 32'(data7), 32'(e7[6:0]));
        check("perr7", 32'(pe7), 32'(e7[9]));
        check("ferr7", 32'(fe7), 32'(e7[10]));
      end
      words7++;
    end
    if (!reset && ovr8) ovr_cnt8++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_bit(input int w, input logic v, input int n);
    if (w == 0) rx8 = v;
    else        rx7 = v;
    repeat (n) tick();
  endtask

  task automatic send_frame(input int w, input logic [8:0] d, input int nb,
                            input int par, input bit flip, input int stop_low);
    logic p;
    drive_bit(w, 1'b0, BP);
    for (int i = 0; i < nb; i++) drive_bit(w, d[i], BP);
    if (par != 0) begin
      p = 1'b0;
      for (int i = 0; i < nb; i++) p = p ^ d[i];
      if (par == 1) p = ~p;
      drive_bit(w, p ^ flip, BP);
    end
    if (stop_low > 0) drive_bit(w, 1'b0, stop_low);
    drive_bit(w, 1'b1, BP);
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exceeded");
    $fatal(1);
  end

  initial begin
    rx8 = 1'b1; rx7 = 1'b1; ready8 = 1'b1; ready7 = 1'b1; reset = 1'b1;
    idle(3);
    check("rst_valid8",   32'(valid8), 32'd0);
    check("rst_busy8",    32'(busy8),  32'd0);
    check("rst_overrun8", 32'(ovr8),   32'd0);
    check("rst_data8",    32'(data8),  32'd0);
    check("rst_flags8",   32'({fe8, pe8}), 32'd0);
    check("rst_valid7",   32'(valid7), 32'd0);
    reset = 1'b0;
    idle(4);

    // 8N1 back-to-back frames
    q8.push_back({2'b00, 9'h055});
    q8.push_back({2'b00, 9'h0A3});
    send_frame(0, 9'h055, 8, 0, 1'b0, 0);
    send_frame(0, 9'h0A3, 8, 0, 1'b0, 0);
    idle(2 * BP);
    check("t1_words", 32'(words8), 32'd2);
    check("t1_q_empty", 32'(q8.size()), 32'd0);

    // 7E1 with wrong parity bit
    q7.push_back({2'b01, 9'h041});
    send_frame(1, 9'h041, 7, 2, 1'b1, 0);
    idle(2 * BP);
    check("t2_words", 32'(words7), 32'd1);
    check("t2_q_empty", 32'(q7.size()), 32'd0);

    // Stop bit held low: one flagged word, then normal reception
    q8.push_back({2'b10, 9'h00F});
    send_frame(0, 9'h00F, 8, 0, 1'b0, 40);
    idle(2 * BP);
    check("t3_words_after_break", 32'(words8), 32'd3);
    check("t3_busy_idle", 32'(busy8), 32'd0);
    q8.push_back({2'b00, 9'h033});
    send_frame(0, 9'h033, 8, 0, 1'b0, 0);
    idle(2 * BP);
    check("t3_words", 32'(words8), 32'd4);
    check("t3_q_empty", 32'(q8.size()), 32'd0);

    // Short low glitch on idle line
    rx8 = 1'b0;
    idle(5);
    check("t4_busy_during", 32'(busy8), 32'd1);
    rx8 = 1'b1;
    idle(2 * BP);
    check("t4_busy_after", 32'(busy8), 32'd0);
    check("t4_valid", 32'(valid8), 32'd0);
    check("t4_words", 32'(words8), 32'd4);

    // Fill the FIFO with ready low, fifth word overruns
    ready8 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      q8.push_back({2'b00, 9'(i)});
      send_frame(0, 9'(i), 8, 0, 1'b0, 0);
    end
    idle(4);
    check("t5_no_overrun_yet", 32'(ovr_cnt8), 32'd0);
    check("t5_valid_full", 32'(valid8), 32'd1);
    check("t5_head_hold", 32'(data8), 32'h01);
    send_frame(0, 9'h005, 8, 0, 1'b0, 0);
    idle(4);
    check("t5_overrun_once", 32'(ovr_cnt8), 32'd1);
    check("t5_head_after_drop", 32'(data8), 32'h01);
    ready8 = 1'b1;
    idle(8);
    check("t5_q_empty", 32'(q8.size()), 32'd0);
    check("t5_valid_drained", 32'(valid8), 32'd0);
    check("t5_words", 32'(words8), 32'd8);

    // Reset in the middle of a data bit
    drive_bit(0, 1'b0, BP);
    drive_bit(0, 1'b0, BP);
    drive_bit(0, 1'b1, BP);
    drive_bit(0, 1'b1, BP / 2);
    check("t6_busy_mid", 32'(busy8), 32'd1);
    reset = 1'b1;
    rx8 = 1'b1;
    tick();
    check("t6_rst_data",  32'(data8), 32'd0);
    check("t6_rst_flags", 32'({fe8, pe8}), 32'd0);
    check("t6_rst_valid", 32'(valid8), 32'd0);
    check("t6_rst_ovr",   32'(ovr8), 32'd0);
    check("t6_rst_busy",  32'(busy8), 32'd0);
    tick();
    reset = 1'b0;
    idle(4);
    q8.push_back({2'b00, 9'h012});
    send_frame(0, 9'h012, 8, 0, 1'b0, 0);
    idle(2 * BP);
    check("t6_words", 32'(words8), 32'd9);
    check("t6_q_empty", 32'(q8.size()), 32'd0);
    check("t6_valid_end", 32'(valid8), 32'd0);
    check("t6_words7", 32'(words7), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver for the RS-232 path.
- Frame format is configurable: data bits, parity and stop bits.
- Start bit is sampled mid-bit and glitch-rejected.
- Parity and framing errors are reported per word.
- Received words are buffered in a small FIFO and delivered over a valid/ready interface to the downstream command/data consumer.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate. BIT_PERIOD = CLK_FREQ/BAUD_RATE clocks; HALF_PERIOD = BIT_PERIOD/2.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: received-word buffer depth; power of 2, at least 2.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- rx, input, 1: asynchronous serial line, idle high.
- data_out, output, DATA_BITS: FIFO head word, LSB = first received bit.
- parity_err, output, 1: parity error flag of the head word.
- frame_err, output, 1: framing error flag of the head word.
- valid, output, 1: FIFO non-empty; head word is presentable.
- ready, input, 1: consumer accepts the head word when valid && ready.
- overrun, output, 1: one-cycle pulse when a completed word is dropped because the FIFO is full.
- busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset is asynchronous: reset, active-high; clock clk.
- Reset values:
  - data_out = 0, parity_err = 0, frame_err = 0, valid = 0, overrun = 0, busy = 0.
  - FIFO empty; FSM in IDLE.
  - Synchroniser flops = 1.
- rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s.
- Bit counter cnt runs 0..BIT_PERIOD-1. Width is clog2(BIT_PERIOD).
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
  - IDLE: when rx_s == 0, go to START with cnt = 0.
  - START: at cnt == HALF_PERIOD-1, sample rx_s.
    - If 1: glitch; return to IDLE with no output.
    - If 0: cnt = 0, go to DATA.
  - DATA: every cnt == BIT_PERIOD-1 (mid-bit), shift rx_s into shreg[bit_idx]. After DATA_BITS samples, go to PAR (PARITY != 0) or STOP.
  - PAR: sample the parity bit.
    - parity_bad = (^data ^ bit) != (PARITY == 1).
    - Odd parity means data plus parity bit has an odd number of ones.
  - STOP: sample STOP_BITS stop bits at mid-bit; any 0 sets frame_bad.
    - After the last stop sample, push {frame_bad, parity_bad, data} into the FIFO.
    - If frame_bad, go to BREAK; otherwise go to IDLE.
    - The return to IDLE happens at the mid-stop sample, so back-to-back frames are accepted.
  - BREAK: wait until rx_s == 1, then go to IDLE. A line held low never produces repeated words.
- Latency:
  - The FIFO write occurs on the clock edge following the final stop sample.
  - valid rises the next cycle if the FIFO was empty.
- FIFO behaviour:
  - First-word fall-through; head outputs are stable while valid && !ready.
  - Pop on valid && ready.
  - A simultaneous push and pop with the FIFO full is accepted (no overrun).
  - Push with the FIFO full and no pop: word dropped, overrun pulses 1 cycle, FIFO contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty is resolved with an extra pointer MSB.
- Errored words are still delivered; flags travel with their data.
- Reset mid-frame aborts the frame immediately; the partial word is never written.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: each bit (start, data, parity, stop) is the 2-of-3 majority of rx_s sampled at cnt = mid-1, mid and mid+1. The decision uses the mid+1 sample, so the internal sample point is one clock later; all external latencies grow by 1 clock.
- Undefined: single sample at mid-bit, as described above.

Decomposition:
- Package uart_pkg holds:
  - parity_e enum: NONE, ODD, EVEN.
  - rx_state_e enum: the six FSM states.
  - Function bit_period(clk, baud).
  - Localparam width helpers.
- Sub-module uart_rx_fifo_buf: synchronous FWFT FIFO, parametrised on width and depth. Width = DATA_BITS+2.

Test Plan:
Use CLK_FREQ=160000, BAUD_RATE=10000, so BIT_PERIOD=16.
1. 8N1, send 0x55 then 0xA3 back-to-back, ready = 1 → two valid pulses, data 0x55 then 0xA3, no flags set.
2. PARITY=2, DATA_BITS=7, send 0x41 with parity bit 1 (wrong; correct is 0) → data 0x41, parity_err = 1, frame_err = 0.
3. Stop bit driven 0 for 40 clocks after byte 0x0F → one word 0x0F with frame_err = 1; no further words until rx returns high, then next frame 0x33 is received normally.
4. rx low pulse of 5 clocks on an idle line → busy returns to 0, valid stays 0, no word.
5. FIFO_DEPTH=4, ready = 0, send 5 frames 0x01..0x05 → overrun pulses once at frame 5. Then raise ready → pops 0x01..0x04 in order, then valid = 0.
6. Assert reset mid-DATA of frame 0x7E, then send 0x12 → only 0x12 delivered; all outputs 0 during reset.
